// File: rtl/output_display_ctrl_if.sv
// ---------------------------------------------------------------------------
// output_display_ctrl_if
// OUT-instruction result bus from the pipelined core into the display
// controller.
//   outdisplay : one-cycle strobe, OUT result valid this cycle
//   outsel     : destination display bank (0..7)
//   outval1    : first operand of the OUT (upper half of the bank word)
//   outval2    : second operand of the OUT (lower half of the bank word)
// master = core side, slave = display controller side.
// ---------------------------------------------------------------------------
interface output_display_ctrl_if;
    logic        outdisplay;
    logic [2:0]  outsel;
    logic [15:0] outval1;
    logic [15:0] outval2;

    modport master (output outdisplay, output outsel, output outval1, output outval2);
    modport slave  (input  outdisplay, input  outsel, input  outval1, input  outval2);
endinterface

// File: rtl/output_display_ctrl.sv
// ---------------------------------------------------------------------------
// output_display_ctrl
// Captures OUT results from the core into 8 display banks and scans the bank
// selected by the board switches onto an 8-digit multiplexed 7-segment
// display. Also keeps per-bank fresh flags and a count of OUT strobes.
// Ports:
//   clock, reset     : system clock (shared with the core), async active-high reset
//   core_if          : OUT result bus (slave modport)
//   view_sel         : bank to display, quasi-static switches
//   seg              : {dp,g,f,e,d,c,b,a}, registered
//   an               : one-hot digit enables, registered with seg
//   fresh            : bank k written since it was last fully displayed
//   capture_count    : accepted OUT strobes, modulo 256
// ---------------------------------------------------------------------------
module output_display_ctrl #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter bit          ACTIVE_LOW = 1'b1
) (
    input  logic                         clock,
    input  logic                         reset,
    output_display_ctrl_if.slave         core_if,
    input  logic [2:0]                   view_sel,
    output logic [7:0]                   seg,
    output logic [7:0]                   an,
    output logic [7:0]                   fresh,
    output logic [7:0]                   capture_count
);

    localparam int unsigned     PW         = $clog2(SCAN_DIV);
    localparam logic [PW-1:0]   PRESC_MAX  = PW'(SCAN_DIV - 1);
    localparam logic [7:0]      SEG_RESET  = ACTIVE_LOW ? 8'hC0 : 8'h3F;
    localparam logic [7:0]      AN_RESET   = ACTIVE_LOW ? 8'hFE : 8'h01;

    logic [31:0]   bank_q [8];
    logic [7:0]    fresh_q, fresh_d;
    logic [7:0]    count_q, count_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    digit_q, digit_d;
    logic [7:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;

    logic          presc_wrap;
    logic          scan_wrap;
    logic [31:0]   view_word;
    logic [3:0]    nibble;
    logic [7:0]    seg_raw;
    logic [7:0]    an_raw;

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: glyph = 7'h3F;
            4'h1: glyph = 7'h06;
            4'h2: glyph = 7'h5B;
            4'h3: glyph = 7'h4F;
            4'h4: glyph = 7'h66;
            4'h5: glyph = 7'h6D;
            4'h6: glyph = 7'h7D;
            4'h7: glyph = 7'h07;
            4'h8: glyph = 7'h7F;
            4'h9: glyph = 7'h6F;
            4'hA: glyph = 7'h77;
            4'hB: glyph = 7'h7C;
            4'hC: glyph = 7'h39;
            4'hD: glyph = 7'h5E;
            4'hE: glyph = 7'h79;
            default: glyph = 7'h71;
        endcase
    endfunction

    always_comb begin
        presc_wrap = (presc_q == PRESC_MAX);
        scan_wrap  = presc_wrap && (digit_q == 3'd7);
        presc_d    = presc_wrap ? '0 : presc_q + 1'b1;
        digit_d    = presc_wrap ? digit_q + 3'd1 : digit_q;

        // Clear first so a same-cycle capture to the viewed bank keeps it fresh.
        fresh_d = fresh_q;
        if (scan_wrap) begin
            fresh_d[view_sel] = 1'b0;
        end
        count_d = count_q;
        if (core_if.outdisplay) begin
            fresh_d[core_if.outsel] = 1'b1;
            count_d = count_q + 8'd1;
        end

        // Bank word is {outval1, outval2}, so digit i is simply nibble i.
        view_word = bank_q[view_sel];
        nibble    = view_word[{digit_q, 2'b00} +: 4];
        seg_raw   = {(digit_q == 3'd4), glyph(nibble)};
        an_raw    = 8'b1 << digit_q;
        seg_d     = ACTIVE_LOW ? ~seg_raw : seg_raw;
        an_d      = ACTIVE_LOW ? ~an_raw  : an_raw;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 8; k++) begin
                bank_q[k] <= '0;
            end
        end else if (core_if.outdisplay) begin
            bank_q[core_if.outsel] <= {core_if.outval1, core_if.outval2};
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fresh_q <= '0;
            count_q <= '0;
            presc_q <= '0;
            digit_q <= '0;
            seg_q   <= SEG_RESET;
            an_q    <= AN_RESET;
        end else begin
            fresh_q <= fresh_d;
            count_q <= count_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign seg           = seg_q;
    assign an            = an_q;
    assign fresh         = fresh_q;
    assign capture_count = count_q;

endmodule

// File: tb/tb_output_display_ctrl.sv
module tb_output_display_ctrl;

    localparam int unsigned SCAN_DIV   = 4;
    localparam bit          ACTIVE_LOW = 1'b1;
    localparam int unsigned SCAN_LEN   = SCAN_DIV * 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] view_sel;
    logic [7:0] seg, an, fresh, capture_count;

    output_display_ctrl_if bus ();

    output_display_ctrl #(.SCAN_DIV(SCAN_DIV), .ACTIVE_LOW(ACTIVE_LOW)) dut (
        .clock         (clock),
        .reset         (reset),
        .core_if       (bus),
        .view_sel      (view_sel),
        .seg           (seg),
        .an            (an),
        .fresh         (fresh),
        .capture_count (capture_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    logic [6:0]  glyph_m [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [31:0] bank_m [8];
    logic [7:0]  fresh_m, count_m, seg_m, an_m;
    int unsigned n_edges;
    int unsigned d_m;

    function automatic logic [7:0] exp_seg(input logic [31:0] w, input int d);
        logic [7:0] raw;
        raw = {(d == 4), glyph_m[w[4*d +: 4]]};
        return ACTIVE_LOW ? ~raw : raw;
    endfunction

    function automatic logic [7:0] exp_an(input int d);
        logic [7:0] raw;
        raw = 8'd1 << d;
        return ACTIVE_LOW ? ~raw : raw;
    endfunction

    // n_edges counts clock edges since reset release; the digit being indexed
    // after n edges is (n / SCAN_DIV) mod 8, and one full scan ends every
    // SCAN_LEN edges.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            n_edges = 0;
            for (int k = 0; k < 8; k++) bank_m[k] = '0;
            fresh_m = '0;
            count_m = '0;
            seg_m   = exp_seg(32'd0, 0);
            an_m    = exp_an(0);
        end else begin
            d_m   = (n_edges / SCAN_DIV) % 8;
            seg_m = exp_seg(bank_m[view_sel], int'(d_m));
            an_m  = exp_an(int'(d_m));
            if (((n_edges + 1) % SCAN_LEN) == 0) fresh_m[view_sel] = 1'b0;
            if (bus.outdisplay) begin
                bank_m[bus.outsel]  = {bus.outval1, bus.outval2};
                fresh_m[bus.outsel] = 1'b1;
                count_m             = count_m + 8'd1;
            end
            n_edges++;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 1000000", $time);
        $fatal(1);
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [7:0] prev_an;
        int run;
        int changes;
        reset = 1'b1;
        bus.outdisplay = 1'b0;
        bus.outsel = '0;
        bus.outval1 = '0;
        bus.outval2 = '0;
        view_sel = '0;
        @(negedge clock);
        @(negedge clock);
        n_checks++; if (an !== 8'hFE) begin n_errors++; $display("FAIL reset_an: got %h expected fe", an); end
        n_checks++; if (seg !== 8'hC0) begin n_errors++; $display("FAIL reset_seg: got %h expected c0", seg); end
        n_checks++; if (fresh !== 8'h00) begin n_errors++; $display("FAIL reset_fresh: got %h expected 00", fresh); end
        n_checks++; if (capture_count !== 8'h00) begin n_errors++; $display("FAIL reset_count: got %h expected 00", capture_count); end
        reset = 1'b0;
        prev_an = an;
        run = 0;
        changes = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clock);
            n_checks++; if (an !== an_m) begin n_errors++; $display("FAIL idle_an: got %h expected %h", an, an_m); end
            n_checks++; if (seg !== ((an == 8'hEF) ? 8'h40 : 8'hC0)) begin
                n_errors++; $display("FAIL idle_seg: got %h expected %h (an %h)", seg, (an == 8'hEF) ? 8'h40 : 8'hC0, an);
            end
            if (an == prev_an) begin
                run++;
            end else begin
                if (changes > 0) begin
                    n_checks++; if (run != SCAN_DIV) begin n_errors++; $display("FAIL digit_dwell: got %0d expected %0d", run, SCAN_DIV); end
                end
                changes++;
                run = 1;
                prev_an = an;
            end
        end
        n_checks++; if (fresh !== 8'h00 || capture_count !== 8'h00) begin
            n_errors++; $display("FAIL idle_state: got fresh %h count %h expected 00 00", fresh, capture_count);
        end
    endtask

    task automatic test_capture();
        view_sel = 3'd3;
        bus.outsel = 3'd3;
        bus.outval1 = 16'h12AB;
        bus.outval2 = 16'h00F0;
        bus.outdisplay = 1'b1;
        @(negedge clock);
        bus.outdisplay = 1'b0;
        n_checks++; if (fresh !== 8'h08) begin n_errors++; $display("FAIL cap_fresh: got %h expected 08", fresh); end
        n_checks++; if (capture_count !== 8'd1) begin n_errors++; $display("FAIL cap_count: got %h expected 01", capture_count); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            n_checks++; if (seg !== seg_m || an !== an_m) begin
                n_errors++; $display("FAIL cap_display: got seg %h an %h expected seg %h an %h", seg, an, seg_m, an_m);
            end
            n_checks++; if (fresh !== fresh_m) begin n_errors++; $display("FAIL cap_fresh_track: got %h expected %h", fresh, fresh_m); end
            if (an == 8'hFE) begin
                n_checks++; if (seg !== 8'hC0) begin n_errors++; $display("FAIL cap_digit0: got %h expected c0", seg); end
            end
            if (an == 8'hFD) begin
                n_checks++; if (seg !== 8'h8E) begin n_errors++; $display("FAIL cap_digit1: got %h expected 8e", seg); end
            end
            if (an == 8'h7F) begin
                n_checks++; if (seg !== 8'hF9) begin n_errors++; $display("FAIL cap_digit7: got %h expected f9", seg); end
            end
        end
        n_checks++; if (fresh[3] !== 1'b0) begin n_errors++; $display("FAIL cap_fresh_clear: got %b expected 0", fresh[3]); end
    endtask

    task automatic test_wrap_collision();
        int budget;
        view_sel = 3'd5;
        budget = 0;
        while (((n_edges + 1) % SCAN_LEN) != 0 && budget < 2 * SCAN_LEN) begin
            @(negedge clock);
            budget++;
        end
        n_checks++; if (((n_edges + 1) % SCAN_LEN) != 0) begin
            n_errors++; $display("FAIL wrap_wait: got edge %0d expected a wrap-1 edge", n_edges);
        end
        bus.outsel = 3'd5;
        bus.outval1 = 16'($urandom);
        bus.outval2 = 16'($urandom);
        bus.outdisplay = 1'b1;
        @(negedge clock);
        bus.outdisplay = 1'b0;
        n_checks++; if (fresh[5] !== 1'b1) begin n_errors++; $display("FAIL wrap_set_wins: got %b expected 1", fresh[5]); end
        for (int i = 0; i < SCAN_LEN; i++) begin
            @(negedge clock);
            n_checks++; if (fresh !== fresh_m || seg !== seg_m) begin
                n_errors++; $display("FAIL wrap_track: got fresh %h seg %h expected %h %h", fresh, seg, fresh_m, seg_m);
            end
        end
        n_checks++; if (fresh[5] !== 1'b0) begin n_errors++; $display("FAIL wrap_next_clear: got %b expected 0", fresh[5]); end
    endtask

    task automatic test_back_to_back();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        view_sel = 3'd7;
        for (int i = 0; i < 257; i++) begin
            bus.outsel = 3'(i % 8);
            bus.outval1 = 16'($urandom);
            bus.outval2 = 16'($urandom);
            bus.outdisplay = 1'b1;
            @(negedge clock);
            n_checks++; if (capture_count !== count_m || seg !== seg_m) begin
                n_errors++; $display("FAIL b2b_track: got count %h seg %h expected %h %h", capture_count, seg, count_m, seg_m);
            end
        end
        bus.outdisplay = 1'b0;
        n_checks++; if (capture_count !== 8'd1) begin n_errors++; $display("FAIL b2b_count: got %h expected 01", capture_count); end
        n_checks++; if (fresh !== 8'hFF) begin n_errors++; $display("FAIL b2b_fresh: got %h expected ff", fresh); end
        for (int b = 0; b < 8; b++) begin
            view_sel = 3'(b);
            for (int i = 0; i < SCAN_LEN + 2; i++) begin
                @(negedge clock);
                n_checks++; if (seg !== seg_m || an !== an_m) begin
                    n_errors++; $display("FAIL b2b_bank%0d: got seg %h an %h expected %h %h", b, seg, an, seg_m, an_m);
                end
            end
        end
    endtask

    task automatic test_view_switch();
        int budget;
        bus.outsel = 3'd0;
        bus.outval1 = 16'($urandom);
        bus.outval2 = 16'($urandom);
        bus.outdisplay = 1'b1;
        @(negedge clock);
        bus.outsel = 3'd3;
        bus.outval2 = bus.outval2 ^ 16'h0F00;
        @(negedge clock);
        bus.outdisplay = 1'b0;
        view_sel = 3'd3;
        budget = 0;
        while (!(an_m == exp_an(2) && (n_edges % SCAN_DIV) == 1) && budget < 3 * SCAN_LEN) begin
            @(negedge clock);
            budget++;
        end
        n_checks++; if (an !== 8'hFB) begin n_errors++; $display("FAIL view_pre_an: got %h expected fb", an); end
        view_sel = 3'd0;
        @(negedge clock);
        n_checks++; if (an !== 8'hFB) begin n_errors++; $display("FAIL view_an_hold: got %h expected fb", an); end
        n_checks++; if (seg !== exp_seg(bank_m[0], 2)) begin
            n_errors++; $display("FAIL view_new_bank: got %h expected %h", seg, exp_seg(bank_m[0], 2));
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clock);
            n_checks++; if (an !== an_m || seg !== seg_m) begin
                n_errors++; $display("FAIL view_continue: got an %h seg %h expected %h %h", an, seg, an_m, seg_m);
            end
        end
    endtask

    task automatic test_reset_midscan();
        int budget;
        for (int b = 0; b < 8; b++) begin
            bus.outsel = 3'(b);
            bus.outval1 = 16'($urandom) | 16'h1111;
            bus.outval2 = 16'($urandom) | 16'h1111;
            bus.outdisplay = 1'b1;
            @(negedge clock);
        end
        bus.outdisplay = 1'b0;
        view_sel = 3'($urandom_range(0, 7));
        budget = 0;
        while (an_m != exp_an(5) && budget < 2 * SCAN_LEN) begin
            @(negedge clock);
            budget++;
        end
        n_checks++; if (an !== 8'hDF) begin n_errors++; $display("FAIL rst_pre_an: got %h expected df", an); end
        bus.outdisplay = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        n_checks++; if (an !== 8'hFE) begin n_errors++; $display("FAIL rst_async_an: got %h expected fe", an); end
        n_checks++; if (seg !== 8'hC0) begin n_errors++; $display("FAIL rst_async_seg: got %h expected c0", seg); end
        n_checks++; if (fresh !== 8'h00) begin n_errors++; $display("FAIL rst_async_fresh: got %h expected 00", fresh); end
        n_checks++; if (capture_count !== 8'h00) begin n_errors++; $display("FAIL rst_async_count: got %h expected 00", capture_count); end
        @(negedge clock);
        bus.outdisplay = 1'b0;
        reset = 1'b0;
        for (int b = 0; b < 8; b++) begin
            view_sel = 3'(b);
            for (int i = 0; i < SCAN_LEN + 1; i++) begin
                @(negedge clock);
                n_checks++; if (seg !== ((an == 8'hEF) ? 8'h40 : 8'hC0)) begin
                    n_errors++; $display("FAIL rst_bank%0d_zero: got %h expected %h", b, seg, (an == 8'hEF) ? 8'h40 : 8'hC0);
                end
            end
        end
        n_checks++; if (capture_count !== 8'h00) begin n_errors++; $display("FAIL rst_lost_capture: got %h expected 00", capture_count); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            bus.outdisplay = ($urandom_range(0, 1) == 1);
            bus.outsel = 3'($urandom);
            bus.outval1 = 16'($urandom);
            bus.outval2 = 16'($urandom);
            if ($urandom_range(0, 19) == 0) view_sel = 3'($urandom);
            @(negedge clock);
            n_checks++; if (seg !== seg_m || an !== an_m) begin
                n_errors++; $display("FAIL rand_display: got seg %h an %h expected %h %h", seg, an, seg_m, an_m);
            end
            n_checks++; if (fresh !== fresh_m || capture_count !== count_m) begin
                n_errors++; $display("FAIL rand_state: got fresh %h count %h expected %h %h", fresh, capture_count, fresh_m, count_m);
            end
        end
        bus.outdisplay = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture();
        test_wrap_collision();
        test_back_to_back();
        test_view_switch();
        test_reset_midscan();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/output_display_ctrl.md
Name: output_display_ctrl

Overview:
- Sits directly downstream of the pipelined processor core and consumes its OUT-instruction results (outval1, outval2, outsel, outdisplay).
- Latches each OUT result into one of 8 display banks.
- Drives an 8-digit time-multiplexed 7-segment display showing the bank chosen by board switches.
- Tracks per-bank "fresh data" flags and a running count of OUT events.

Parameters:
- SCAN_DIV, 50000: clock cycles each digit stays enabled; legal range 2..2^20.
- ACTIVE_LOW, 1: 1 = segment and anode outputs active-low; 0 = active-high.

Ports:
- clock  in  1  system clock; same clock as the processor core
- reset  in  1  reset, asynchronous, active-high
- outdisplay  in  1  one-cycle strobe; OUT instruction result valid this cycle
- outsel  in  3  destination bank index for the current OUT
- outval1  in  16  first operand value of the OUT
- outval2  in  16  second operand value of the OUT
- view_sel  in  3  bank to display (switches; asynchronous to the core, treated as quasi-static)
- seg  out  8  {dp,g,f,e,d,c,b,a}
- an  out  8  digit enables, one-hot; bit i = digit i
- fresh  out  8  bit k = bank k written since it was last fully displayed
- capture_count  out  8  number of OUT strobes accepted, modulo 256

Behaviour:
- Reset (async) values:
  - all banks = 0; fresh = 0; capture_count = 0; prescaler = 0; digit index = 0.
  - an = digit 0 enabled: 8'hFE if ACTIVE_LOW, else 8'h01.
  - seg = glyph "0" with dp off: 8'hC0 if ACTIVE_LOW, else 8'h3F.
- Capture:
  - On a rising edge with outdisplay=1: bank[outsel] <= {outval1, outval2}; fresh[outsel] <= 1; capture_count <= capture_count + 1 (wraps 255 -> 0).
  - No handshake or backpressure; every strobe is accepted.
  - Strobes on consecutive cycles are all captured.
  - Same bank written twice: last write wins.
- Prescaler:
  - Counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1 it wraps to 0 and the digit index advances by 1 (7 wraps to 0).
  - Each digit is therefore enabled for exactly SCAN_DIV cycles.
- Digit mapping for bank B = bank[view_sel]:
  - Digit i, i in 0..3, shows hex nibble outval2[4i+3:4i].
  - Digit i, i in 4..7, shows hex nibble outval1[4(i-4)+3:4(i-4)].
  - dp is lit on digit 4 only, as a separator between the two values.
- Glyphs, active-high {g..a}:
  - 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07
  - 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71
  - ACTIVE_LOW inverts all 8 seg bits and all an bits.
- Output registration:
  - seg and an are registered and updated together every cycle from the current digit index, view_sel and bank contents.
  - Latency is 1 cycle from any bank write, view_sel change or digit advance to the seg/an outputs.
  - seg and an never disagree about which digit is shown.
- Fresh clearing:
  - fresh[view_sel] <= 0 on the cycle the digit index wraps 7 -> 0, i.e. one full scan of that bank is completed.
  - If a capture to the same bank occurs that same cycle, set wins and fresh stays 1.
  - Captures to other banks are unaffected.
- view_sel change mid-scan:
  - No reset of the scan; remaining digits show the new bank.
  - The new bank's fresh bit clears only at the next 7 -> 0 wrap.
- Reset asserted mid-scan or mid-capture: all state returns to the reset values immediately; the in-flight capture is lost.

Test Plan:
- Reset, SCAN_DIV=4, ACTIVE_LOW=1, no strobes -> an cycles FE,FD,FB,F7,EF,DF,BF,7F, 4 cycles each, then repeats.
  - seg=C0 on every digit except digit 4, where seg=40 (dp on).
  - fresh=0; capture_count=0.
- outdisplay pulse with outsel=3, outval1=16'h12AB, outval2=16'h00F0, view_sel=3 -> fresh=8'h08 and capture_count=1 the next cycle.
  - Digits 7..0 show 1,2,A,b,0,0,F,0; seg on digit 0 = C0, digit 1 = 8E, digit 7 = F9.
  - fresh[3] clears at the first 7 -> 0 wrap.
- Capture to bank 5 on the exact cycle of a 7 -> 0 wrap with view_sel=5 -> fresh[5] stays 1; it clears at the following wrap.
- 257 back-to-back strobes cycling outsel 0..7 -> capture_count=1; every bank holds its last written value; fresh=8'hFF.
- view_sel switched from 3 to 0 while digit 2 is enabled -> seg shows bank 0's nibble 2 one cycle later; an is unchanged and the scan continues.
- reset asserted asynchronously mid-digit-5 with banks loaded -> an=FE, seg=C0, fresh=0, capture_count=0 before the next clock edge; after release, all banks read 0.
